sonar_ranger: RTL and testbench
===============================

# sonar_ranger

Measurement sequencer and post-processor placed directly around the HC-SR04 echo-timer block. It issues the timer's active-low `get` request at a fixed period and consumes the timer's `data`/`ready` result. It converts echo ticks to centimetres, maintains a power-of-two moving average, and drives a proximity flag with hysteresis. A watchdog recovers the timer when an echo never completes.

## Interface
- `PERIOD_TICKS`, default 120000: clocks between request starts (60 ms at 2 MHz).
- `TIMEOUT_TICKS`, default 60000: maximum clocks to wait for `ready` after a request.
- `TICKS_PER_CM`, default 116: echo ticks per centimetre (58 µs/cm at 2 MHz); range 1..65535.
- `AVG_LOG2`, default 2: moving-average depth is 2^AVG_LOG2; range 0..4.
- `NEAR_CM`, default 20: `near` sets when the average is below this value.
- `FAR_CM`, default 25: `near` clears when the average is at or above this value; must be ≥ `NEAR_CM`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low.
- `enable` in 1: when high, periodic measurement runs.
- `get` out 1: request to the timer; idle high; low for exactly one cycle per request.
- `ready` in 1: one-cycle pulse from the timer; `data` is valid in that cycle.
- `data` in 16: echo width in ticks.
- `sensor_rst_n` out 1: timer reset; idle high; low for one cycle on timeout.
- `dist_cm` out 16: latest converted sample.
- `avg_cm` out 16: moving average.
- `dist_valid` out 1: one-cycle pulse when `dist_cm`/`avg_cm` update.
- `near` out 1: proximity flag with hysteresis.
- `timeout` out 1: one-cycle pulse on a watchdog expiry.
- `err_count` out 8: count of timeouts, saturating at 255.

## Operation
- Reset values:
  - `get`=1, `sensor_rst_n`=1.
  - `dist_cm`=0, `avg_cm`=0.
  - `dist_valid`=0, `near`=0, `timeout`=0, `err_count`=0.
  - Ring buffer and sum are 0; the primed flag is clear; state is IDLE.
- States:
  - IDLE: if `enable`=1, go to REQ.
  - REQ: `get`=0 for one cycle; clear the wait counter and period counter; go to WAIT.
  - WAIT: if `ready`=1, latch `data` and go to DIV. If the wait counter reaches TIMEOUT_TICKS-1 without `ready`, pulse `timeout`, pulse `sensor_rst_n` low, increment `err_count` (saturating), and go to HOLD. Otherwise increment the wait counter.
  - DIV: 16-cycle restoring divide of the latched data by TICKS_PER_CM; the quotient is truncated. Then go to UPD.
  - UPD (one cycle):
    - Register `dist_cm` = quotient.
    - If the primed flag is clear: fill every ring entry with the quotient, set sum = quotient << AVG_LOG2, and set the primed flag.
    - Otherwise: sum = sum − oldest + quotient, and overwrite the oldest entry; the write pointer wraps modulo 2^AVG_LOG2.
    - Register `avg_cm` = new sum >> AVG_LOG2.
    - Update `near`: set if `avg_cm` < NEAR_CM, clear if `avg_cm` ≥ FAR_CM, otherwise hold.
    - Pulse `dist_valid`. Go to HOLD.
  - HOLD: when the period counter reaches PERIOD_TICKS-1, go to REQ if `enable`=1, else IDLE.
- Arithmetic: sum width is 16+AVG_LOG2; there is no overflow. `data`=0 gives 0 cm.
- `ready` outside WAIT is ignored.
- If `ready` and the timeout terminal count fall in the same cycle, `ready` wins and no timeout is raised.
- Deasserting `enable` mid-measurement does not abort: the current measurement completes, then HOLD returns to IDLE. Reasserting `enable` in IDLE issues REQ on the next cycle.
- Reset mid-operation: every register returns to its reset value, and the next sample re-primes the ring.

## Timing
- The period counter runs from the REQ cycle. Request spacing is exactly PERIOD_TICKS clocks when PERIOD_TICKS > TIMEOUT_TICKS + 20. Otherwise the next REQ follows HOLD entry by one cycle.
- If `ready`=1 is sampled in cycle t, then `dist_valid`=1 in cycle t+18, and `dist_cm`, `avg_cm` and `near` are new in that same cycle.
- `timeout` and `sensor_rst_n`=0 are coincident and last one cycle. `err_count` shows the new value in the following cycle.
- All outputs are registered.

## Structure
- Shared package `sonar_pkg`: state enum (IDLE, REQ, WAIT, DIV, UPD, HOLD) and default parameter constants for a 2 MHz clock.
- Sub-module `udiv16`: 16-bit sequential restoring divider with start/done handshake and a fixed latency of 16 cycles.
- Ring buffer, sum, hysteresis logic and FSM stay in the top module.

## Test plan
Bench parameters: PERIOD_TICKS=200, TIMEOUT_TICKS=100, TICKS_PER_CM=116, AVG_LOG2=2.
- Reset, then `enable`=1 → `get` low for one cycle, one cycle after reset is released; `get` high afterwards; all outputs at reset values until the first `ready`.
- Model returns `ready` with `data`=2320 → 18 cycles later `dist_valid`=1, `dist_cm`=20, `avg_cm`=20 (primed), `near`=0.
- Samples 2320, 0, 0, 0 (20 cm then three 0 cm) → `avg_cm` sequence 20, 15, 10, 5; `near` sets at the 15 reading.
- Hysteresis: from `near`=1, feed 23 cm repeatedly → `near` stays 1. Feed 30 cm until `avg_cm` ≥ 25 → `near` clears on that update.
- No `ready` after a request → `timeout` and `sensor_rst_n`=0 exactly 100 cycles after `get` low; `err_count`=1; next `get` 200 cycles after the previous one. 256 timeouts → `err_count` holds 255.
- Corner cases: `ready` on the timeout terminal cycle → no `timeout`, `dist_valid` 18 cycles later. `enable` dropped during WAIT → sample still delivered, then no further `get`. `reset` asserted during DIV → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar ranging sequencer: FSM state encoding,
// default timing constants for a 2 MHz clock, and small arithmetic helpers.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DIV  = 3'd3,
    UPD  = 3'd4,
    HOLD = 3'd5
  } state_t;

  // Defaults for a 2 MHz clock: 60 ms period, 30 ms echo limit, 58 us/cm.
  localparam int unsigned PERIOD_TICKS_DEF  = 120000;
  localparam int unsigned TIMEOUT_TICKS_DEF = 60000;
  localparam int unsigned TICKS_PER_CM_DEF  = 116;
  localparam int unsigned AVG_LOG2_DEF      = 2;
  localparam int unsigned NEAR_CM_DEF       = 20;
  localparam int unsigned FAR_CM_DEF        = 25;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sonar_ranger_udiv16.sv
// 16-bit sequential restoring divider. A start pulse loads the operands;
// one quotient bit is produced per cycle. done is high during the 16th
// iteration cycle, and quotient holds the final result from the next cycle
// until the following start.
module udiv16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        done,
  output logic [15:0] quotient
);

  logic [15:0] quo_q, quo_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [16:0] rem_shift;
  logic [16:0] diff;

  // One restoring step per busy cycle: shift in the next dividend bit, try
  // the subtraction, keep it only when it does not go negative.
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    rem_shift = {rem_q, quo_q[15]};
    diff      = rem_shift - {1'b0, divisor};
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!diff[16]) begin
        rem_d = diff[15:0];
        quo_d = {quo_q[14:0], 1'b1};
      end else begin
        rem_d = rem_shift[15:0];
        quo_d = {quo_q[14:0], 1'b0};
      end
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        busy_d = 1'b0;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done     = busy_q && (cnt_q == 4'd15);
  assign quotient = quo_q;

endmodule

// File: rtl/sonar_ranger.sv
// Periodic HC-SR04 measurement sequencer: requests an echo, converts ticks to
// centimetres, keeps a power-of-two moving average, drives a hysteretic
// proximity flag and recovers the echo timer when it never answers.
//
// Handshakes: get is a one-cycle active-low request; the timer answers with a
// one-cycle ready pulse and data is valid only in that cycle. ready is only
// honoured in WAIT. Internally the divider takes a one-cycle start pulse with
// its operand and raises done in its final iteration cycle.
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS  = PERIOD_TICKS_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int unsigned TICKS_PER_CM  = TICKS_PER_CM_DEF,
  parameter int unsigned AVG_LOG2      = AVG_LOG2_DEF,
  parameter int unsigned NEAR_CM       = NEAR_CM_DEF,
  parameter int unsigned FAR_CM        = FAR_CM_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        get,
  input  logic        ready,
  input  logic [15:0] data,
  output logic        sensor_rst_n,
  output logic [15:0] dist_cm,
  output logic [15:0] avg_cm,
  output logic        dist_valid,
  output logic        near,
  output logic        timeout,
  output logic [7:0]  err_count,
  output logic [2:0]  dbg_state
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned SUM_W = 16 + AVG_LOG2;

  state_t             state_q, state_d;
  logic               get_q, get_d;
  logic               rst_n_q, rst_n_d;
  logic [15:0]        dist_q, dist_d;
  logic [15:0]        avg_q, avg_d;
  logic               dv_q, dv_d;
  logic               near_q, near_d;
  logic               to_q, to_d;
  logic [7:0]         err_q, err_d;
  logic [31:0]        wait_q, wait_d;
  logic [31:0]        period_q, period_d;
  logic [15:0]        ring_q [DEPTH];
  logic [15:0]        ring_d [DEPTH];
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               primed_q, primed_d;

  logic               div_start;
  logic               div_done;
  logic [15:0]        quo;
  logic [SUM_W-1:0]   sum_new;
  logic [15:0]        avg_new;
  logic [15:0]        oldest;

  udiv16 u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (data),
    .divisor  (16'(TICKS_PER_CM)),
    .done     (div_done),
    .quotient (quo)
  );

  // Sequencer next state, averaging datapath and registered output values.
  // Both counters treat the REQ cycle as tick 0, so they read 1 in the cycle
  // after REQ and a terminal value N-1 lands exactly N-1 cycles after get.
  always_comb begin
    state_d   = state_q;
    rst_n_d   = 1'b1;
    dv_d      = 1'b0;
    to_d      = 1'b0;
    dist_d    = dist_q;
    avg_d     = avg_q;
    near_d    = near_q;
    err_d     = to_q ? sat_inc8(err_q) : err_q;
    wait_d    = wait_q;
    period_d  = (period_q == 32'hFFFF_FFFF) ? period_q : period_q + 32'd1;
    ring_d    = ring_q;
    sum_d     = sum_q;
    ptr_d     = ptr_q;
    primed_d  = primed_q;
    div_start = 1'b0;
    sum_new   = '0;
    avg_new   = '0;
    oldest    = ring_q[ptr_q];

    case (state_q)
      IDLE: begin
        if (enable) state_d = REQ;
      end
      REQ: begin
        wait_d   = 32'd1;
        period_d = 32'd1;
        state_d  = WAIT;
      end
      WAIT: begin
        // A ready in the terminal cycle still counts as an answer.
        if (ready) begin
          div_start = 1'b1;
          state_d   = DIV;
        end else if (wait_q >= TIMEOUT_TICKS - 1) begin
          to_d    = 1'b1;
          rst_n_d = 1'b0;
          state_d = HOLD;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      DIV: begin
        if (div_done) state_d = UPD;
      end
      UPD: begin
        if (!primed_q) begin
          // First sample after reset seeds the whole window.
          ring_d   = '{default: quo};
          sum_new  = SUM_W'(quo) << AVG_LOG2;
          ptr_d    = '0;
          primed_d = 1'b1;
        end else begin
          sum_new       = sum_q - SUM_W'(oldest) + SUM_W'(quo);
          ring_d[ptr_q] = quo;
          ptr_d         = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
        sum_d   = sum_new;
        avg_new = 16'(sum_new >> AVG_LOG2);
        dist_d  = quo;
        avg_d   = avg_new;
        if (avg_new < 16'(NEAR_CM)) begin
          near_d = 1'b1;
        end else if (avg_new >= 16'(FAR_CM)) begin
          near_d = 1'b0;
        end
        dv_d    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (period_q >= PERIOD_TICKS - 1) state_d = enable ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase

    get_d = (state_d != REQ);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      get_q    <= 1'b1;
      rst_n_q  <= 1'b1;
      dist_q   <= '0;
      avg_q    <= '0;
      dv_q     <= 1'b0;
      near_q   <= 1'b0;
      to_q     <= 1'b0;
      err_q    <= '0;
      wait_q   <= '0;
      period_q <= '0;
      ring_q   <= '{default: '0};
      sum_q    <= '0;
      ptr_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      get_q    <= get_d;
      rst_n_q  <= rst_n_d;
      dist_q   <= dist_d;
      avg_q    <= avg_d;
      dv_q     <= dv_d;
      near_q   <= near_d;
      to_q     <= to_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
      period_q <= period_d;
      ring_q   <= ring_d;
      sum_q    <= sum_d;
      ptr_q    <= ptr_d;
      primed_q <= primed_d;
    end
  end

  assign get          = get_q;
  assign sensor_rst_n = rst_n_q;
  assign dist_cm      = dist_q;
  assign avg_cm       = avg_q;
  assign dist_valid   = dv_q;
  assign near         = near_q;
  assign timeout      = to_q;
  assign err_count    = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Bench for sonar_ranger: an echo-timer model answers requests with random
// echo widths and delays; a window-average reference model predicts each
// reported sample.
`timescale 1ns/1ps
module tb_sonar_ranger;
  import sonar_pkg::*;

  localparam int PERIOD = 200;
  localparam int TMO    = 100;
  localparam int TPC    = 116;
  localparam int ALOG   = 2;
  localparam int DEPTH  = 1 << ALOG;
  localparam int NEARC  = 20;
  localparam int FARC   = 25;

  // ---------------- clock / reset ----------------
  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        enable = 1'b0;
  logic        ready  = 1'b0;
  logic [15:0] data   = '0;
  logic        get;
  logic        sensor_rst_n;
  logic [15:0] dist_cm;
  logic [15:0] avg_cm;
  logic        dist_valid;
  logic        near;
  logic        timeout;
  logic [7:0]  err_count;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL global_time_limit: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit");
  end

  sonar_ranger #(
    .PERIOD_TICKS  (PERIOD),
    .TIMEOUT_TICKS (TMO),
    .TICKS_PER_CM  (TPC),
    .AVG_LOG2      (ALOG),
    .NEAR_CM       (NEARC),
    .FAR_CM        (FARC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .get          (get),
    .ready        (ready),
    .data         (data),
    .sensor_rst_n (sensor_rst_n),
    .dist_cm      (dist_cm),
    .avg_cm       (avg_cm),
    .dist_valid   (dist_valid),
    .near         (near),
    .timeout      (timeout),
    .err_count    (err_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  int          win[$];
  bit          m_primed;
  bit          m_near;
  int          m_avg;
  int          m_err;
  logic [15:0] obs_dist;
  logic [15:0] obs_avg;
  logic        obs_near;

  function automatic void model_reset();
    win.delete();
    exp_q.delete();
    m_primed = 1'b0;
    m_near   = 1'b0;
    m_avg    = 0;
    m_err    = 0;
  endfunction

  // Average of the last DEPTH samples in whole centimetres, window seeded
  // with copies of the first sample after reset.
  function automatic void model_push(input logic [15:0] d);
    int cm;
    int s;
    cm = int'(d) / TPC;
    exp_q.push_back(16'(cm));
    if (!m_primed) begin
      for (int i = 0; i < DEPTH; i++) win.push_back(cm);
      m_primed = 1'b1;
    end else begin
      win.push_back(cm);
      void'(win.pop_front());
    end
    s = 0;
    foreach (win[i]) s += win[i];
    m_avg = s / DEPTH;
    if (m_avg < NEARC) m_near = 1'b1;
    else if (m_avg >= FARC) m_near = 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_get_low(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 450; k++) begin
      @(negedge clk);
      if (get === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL get_request: get stayed %b for 450 cycles, required a low pulse", get);
    end
  endtask

  // Answer the pending request after `delay` cycles and check the result.
  task automatic deliver(input logic [15:0] d, input int delay);
    int          seen_at;
    bit          stray;
    logic [15:0] e_dist;
    stray   = 1'b0;
    seen_at = -1;
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      if (get !== 1'b1 || dist_valid !== 1'b0 || timeout !== 1'b0 || sensor_rst_n !== 1'b1) stray = 1'b1;
    end
    ready = 1'b1;
    data  = d;
    model_push(d);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ready = 1'b0;
        data  = 16'($urandom);
      end
      if (timeout !== 1'b0 || sensor_rst_n !== 1'b1 || get !== 1'b1) stray = 1'b1;
      if (dist_valid === 1'b1) begin
        if (seen_at < 0) seen_at = k;
        else stray = 1'b1;
      end
      if (k == 18) begin
        obs_dist = dist_cm;
        obs_avg  = avg_cm;
        obs_near = near;
      end
    end
    e_dist = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++;
    if (seen_at != 18) begin
      n_fail++;
      $display("FAIL dv_latency: dist_valid first at %0d cycles after ready, required 18", seen_at);
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL quiet_outputs: unexpected get/timeout/sensor_rst_n/dist_valid activity around data=%0d", d);
    end
    n_checks++;
    if (obs_dist !== e_dist) begin
      n_fail++;
      $display("FAIL dist_cm: got %0d, required %0d (data=%0d)", obs_dist, e_dist, d);
    end
    n_checks++;
    if (obs_avg !== 16'(m_avg)) begin
      n_fail++;
      $display("FAIL avg_cm: got %0d, required %0d (data=%0d)", obs_avg, m_avg, d);
    end
    n_checks++;
    if (obs_near !== m_near) begin
      n_fail++;
      $display("FAIL near: got %b, required %b (avg=%0d)", obs_near, m_near, m_avg);
    end
    // A ready while holding must be ignored.
    ready = 1'b1;
    data  = 16'($urandom);
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic measure(input logic [15:0] d, input int delay);
    bit ok;
    wait_get_low(ok);
    if (ok) deliver(d, delay);
  endtask

  // ---------------- tests ----------------
  // Leaves the bench one cycle after the first request.
  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b0;
    ready  = 1'b0;
    data   = '0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (get !== 1'b1 || sensor_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: get=%b sensor_rst_n=%b, required 1 1", get, sensor_rst_n);
    end
    n_checks++;
    if (dist_cm !== 16'd0 || avg_cm !== 16'd0 || dist_valid !== 1'b0 || near !== 1'b0 ||
        timeout !== 1'b0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_data: dist=%0d avg=%0d dv=%b near=%b to=%b err=%0d, required all 0",
               dist_cm, avg_cm, dist_valid, near, timeout, err_count);
    end
    n_checks++;
    if (dbg_state !== 3'(IDLE)) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d, required %0d", dbg_state, IDLE);
    end
    reset  = 1'b1;
    enable = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (get !== 1'b0) begin
      n_fail++;
      $display("FAIL first_get: get=%b one cycle after reset release, required 0", get);
    end
    @(negedge clk);
    n_checks++;
    if (get !== 1'b1 || dist_valid !== 1'b0 || dist_cm !== 16'd0 || avg_cm !== 16'd0) begin
      n_fail++;
      $display("FAIL first_get_end: get=%b dv=%b dist=%0d avg=%0d, required 1 0 0 0",
               get, dist_valid, dist_cm, avg_cm);
    end
  endtask

  task automatic test_first_sample();
    deliver(16'd2320, 19);
    n_checks++;
    if (obs_dist !== 16'd20 || obs_avg !== 16'd20 || obs_near !== 1'b0) begin
      n_fail++;
      $display("FAIL first_sample: dist=%0d avg=%0d near=%b, required 20 20 0", obs_dist, obs_avg, obs_near);
    end
  endtask

  task automatic test_average();
    logic [15:0] samples [4];
    int          exp_avg [4];
    logic        exp_near [4];
    samples[0] = 16'd2320; samples[1] = 16'd0; samples[2] = 16'd0; samples[3] = 16'd0;
    exp_avg[0] = 20; exp_avg[1] = 15; exp_avg[2] = 10; exp_avg[3] = 5;
    exp_near[0] = 1'b0; exp_near[1] = 1'b1; exp_near[2] = 1'b1; exp_near[3] = 1'b1;
    ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      measure(samples[i], int'($urandom_range(1, 99)));
      n_checks++;
      if (obs_avg !== 16'(exp_avg[i]) || obs_near !== exp_near[i]) begin
        n_fail++;
        $display("FAIL avg_sequence[%0d]: avg=%0d near=%b, required %0d %b",
                 i, obs_avg, obs_near, exp_avg[i], exp_near[i]);
      end
    end
  endtask

  task automatic test_hysteresis();
    bit cleared;
    for (int i = 0; i < 4; i++) begin
      measure(16'(23 * TPC + int'($urandom_range(0, TPC - 1))), int'($urandom_range(1, 99)));
      n_checks++;
      if (obs_near !== 1'b1) begin
        n_fail++;
        $display("FAIL hyst_hold[%0d]: near=%b at avg=%0d, required 1", i, obs_near, obs_avg);
      end
    end
    cleared = 1'b0;
    for (int i = 0; i < 8 && !cleared; i++) begin
      measure(16'(30 * TPC + int'($urandom_range(0, TPC - 1))), int'($urandom_range(1, 99)));
      n_checks++;
      if (m_avg >= FARC) begin
        cleared = 1'b1;
        if (obs_near !== 1'b0) begin
          n_fail++;
          $display("FAIL hyst_clear: near=%b at avg=%0d, required 0", obs_near, obs_avg);
        end
      end else if (obs_near !== 1'b1) begin
        n_fail++;
        $display("FAIL hyst_band: near=%b at avg=%0d, required 1", obs_near, obs_avg);
      end
    end
    n_checks++;
    if (!cleared) begin
      n_fail++;
      $display("FAIL hyst_reach: average never reached %0d, required it within 8 samples", FARC);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 4000));
      measure(d, int'($urandom_range(1, 99)));
    end
  endtask

  task automatic test_terminal_ready();
    measure(16'($urandom_range(0, 8000)), TMO - 1);
    n_checks++;
    if (err_count !== 8'(m_err)) begin
      n_fail++;
      $display("FAIL terminal_err: err_count=%0d, required %0d", err_count, m_err);
    end
  endtask

  // Leaves the bench in the cycle of a fresh request.
  task automatic test_enable_drop();
    bit ok;
    bit quiet;
    wait_get_low(ok);
    if (!ok) return;
    @(negedge clk);
    enable = 1'b0;
    deliver(16'($urandom_range(0, 8000)), 30);
    quiet = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (get !== 1'b1) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL disabled_quiet: get went low with enable=0, required no request");
    end
    n_checks++;
    if (dbg_state !== 3'(IDLE)) begin
      n_fail++;
      $display("FAIL disabled_state: state=%0d, required %0d", dbg_state, IDLE);
    end
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (get !== 1'b0) begin
      n_fail++;
      $display("FAIL reenable_req: get=%b one cycle after enable, required 0", get);
    end
  endtask

  task automatic test_reset_in_div();
    logic [15:0] d;
    repeat (10) @(negedge clk);
    ready = 1'b1;
    data  = 16'($urandom_range(0, 8000));
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (get !== 1'b1 || sensor_rst_n !== 1'b1 || dist_cm !== 16'd0 || avg_cm !== 16'd0 ||
        dist_valid !== 1'b0 || near !== 1'b0 || timeout !== 1'b0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL div_reset: get=%b srn=%b dist=%0d avg=%0d dv=%b near=%b to=%b err=%0d, required reset values",
               get, sensor_rst_n, dist_cm, avg_cm, dist_valid, near, timeout, err_count);
    end
    n_checks++;
    if (dbg_state !== 3'(IDLE)) begin
      n_fail++;
      $display("FAIL div_reset_state: state=%0d, required %0d", dbg_state, IDLE);
    end
    model_reset();
    reset = 1'b1;
    d = 16'($urandom_range(0, 8000));
    measure(d, int'($urandom_range(1, 99)));
    n_checks++;
    if (obs_avg !== 16'(int'(d) / TPC)) begin
      n_fail++;
      $display("FAIL reprime: avg=%0d, required %0d", obs_avg, int'(d) / TPC);
    end
  endtask

  task automatic test_timeout();
    bit   ok;
    bit   bad;
    logic to100, srn100, to101, srn101;
    logic [7:0] err101;
    int   gk;
    wait_get_low(ok);
    if (!ok) return;
    bad = 1'b0;
    to100 = 1'b0; srn100 = 1'b1; to101 = 1'b0; srn101 = 1'b1; err101 = '0;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k < 100 && (timeout !== 1'b0 || sensor_rst_n !== 1'b1)) bad = 1'b1;
      if (k == 100) begin
        to100  = timeout;
        srn100 = sensor_rst_n;
      end
      if (k == 101) begin
        to101  = timeout;
        srn101 = sensor_rst_n;
        err101 = err_count;
      end
    end
    if (m_err < 255) m_err++;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL timeout_early: timeout or sensor_rst_n asserted before cycle %0d", TMO);
    end
    n_checks++;
    if (to100 !== 1'b1 || srn100 !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: timeout=%b sensor_rst_n=%b at cycle %0d, required 1 0", to100, srn100, TMO);
    end
    n_checks++;
    if (to101 !== 1'b0 || srn101 !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_width: timeout=%b sensor_rst_n=%b at cycle %0d, required 0 1", to101, srn101, TMO + 1);
    end
    n_checks++;
    if (err101 !== 8'(m_err)) begin
      n_fail++;
      $display("FAIL err_count: got %0d, required %0d", err101, m_err);
    end
    gk = -1;
    for (int k = 102; k <= 350; k++) begin
      @(negedge clk);
      if (get === 1'b0) begin
        gk = k;
        break;
      end
    end
    n_checks++;
    if (gk != PERIOD) begin
      n_fail++;
      $display("FAIL request_spacing: next get after %0d cycles, required %0d", gk, PERIOD);
    end
  endtask

  task automatic test_err_saturation();
    bit found;
    for (int i = 0; i < 256; i++) begin
      found = 1'b0;
      for (int k = 0; k < 260; k++) begin
        @(negedge clk);
        if (timeout === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!found) begin
        n_fail++;
        $display("FAIL timeout_repeat[%0d]: no timeout within 260 cycles, required one", i);
        break;
      end
      if (m_err < 255) m_err++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (err_count !== 8'(m_err)) begin
      n_fail++;
      $display("FAIL err_saturate: err_count=%0d, required %0d", err_count, m_err);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_sample();
    test_average();
    test_hysteresis();
    test_random();
    test_terminal_ready();
    test_enable_drop();
    test_reset_in_div();
    test_timeout();
    test_err_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
